// File: rtl/mem_access_unit.sv
// Load/store front end for a byte-addressed single-cycle memory: valid/ready request in,
// one memory cycle, extended response out. Optional macro MEMIF_ALIGN_CHECK_EN rejects misaligned H/W.
module mem_access_unit #(
  parameter int unsigned pWords         = 32'd44,
  parameter logic        pRspErrOnRange = 1'b1
) (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic        iwReqValid,
  output logic        owReqReady,
  input  logic        iwReqWrite,
  input  logic [2:0]  iwReqFunct3,
  input  logic [31:0] iwReqAddr,
  input  logic [31:0] iwReqData,
  output logic        owRspValid,
  input  logic        iwRspReady,
  output logic [31:0] orRspData,
  output logic        orRspErr,
  output logic [31:0] orMemReadAddr,
  output logic [31:0] orMemWriteAddr,
  output logic [31:0] orMemWriteData,
  output logic [3:0]  orMemWstrb,
  input  logic [31:0] iwMemReadData
);

  localparam logic [32:0] LP_LIMIT = 33'(pWords) * 33'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_write;
  logic [2:0]  r_funct3;

  logic [32:0] w_bytes;
  logic [32:0] w_end;
  logic        w_f3_bad;
  logic        w_range_bad;
  logic        w_align_bad;
  logic        w_illegal;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_ext;

  // Request decode: size, legality and store lane formatting
  always_comb begin
    w_bytes = 33'd1;
    w_wdata = {24'h0, iwReqData[7:0]};
    w_wstrb = 4'b0001;
    unique case (iwReqFunct3[1:0])
      2'b01: begin
        w_bytes = 33'd2;
        w_wdata = {16'h0, iwReqData[15:0]};
        w_wstrb = 4'b0011;
      end
      2'b10: begin
        w_bytes = 33'd4;
        w_wdata = iwReqData;
        w_wstrb = 4'b1111;
      end
      default: begin
        w_bytes = 33'd1;
        w_wdata = {24'h0, iwReqData[7:0]};
        w_wstrb = 4'b0001;
      end
    endcase

    if (iwReqWrite) begin
      w_f3_bad = !(iwReqFunct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_f3_bad = iwReqFunct3 inside {3'b011, 3'b110, 3'b111};
    end

    // 33-bit sum so an address near 2^32 cannot wrap back into range
    w_end       = {1'b0, iwReqAddr} + w_bytes;
    w_range_bad = pRspErrOnRange && (w_end > LP_LIMIT);

    w_align_bad = 1'b0;
`ifdef MEMIF_ALIGN_CHECK_EN
    unique case (iwReqFunct3[1:0])
      2'b01:   w_align_bad = iwReqAddr[0];
      2'b10:   w_align_bad = |iwReqAddr[1:0];
      default: w_align_bad = 1'b0;
    endcase
`endif

    w_illegal = w_f3_bad || w_range_bad || w_align_bad;
  end

  // Load extension on the raw memory word; byte 0 is already at [7:0]
  always_comb begin
    w_ext = iwMemReadData;
    unique case (r_funct3)
      3'b000:  w_ext = {{24{iwMemReadData[7]}}, iwMemReadData[7:0]};
      3'b001:  w_ext = {{16{iwMemReadData[15]}}, iwMemReadData[15:0]};
      3'b100:  w_ext = {24'h0, iwMemReadData[7:0]};
      3'b101:  w_ext = {16'h0, iwMemReadData[15:0]};
      default: w_ext = iwMemReadData;
    endcase
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (iwReqValid) begin
          w_next = w_illegal ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP: begin
        if (iwRspReady) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign owReqReady = (r_state == ST_IDLE);
  assign owRspValid = (r_state == ST_RESP);

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      r_write        <= 1'b0;
      r_funct3       <= '0;
      orRspData      <= '0;
      orRspErr       <= 1'b0;
      orMemReadAddr  <= '0;
      orMemWriteAddr <= '0;
      orMemWriteData <= '0;
      orMemWstrb     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (iwReqValid) begin
            r_write  <= iwReqWrite;
            r_funct3 <= iwReqFunct3;
            if (w_illegal) begin
              orRspErr  <= 1'b1;
              orRspData <= '0;
            end else begin
              orRspErr       <= 1'b0;
              orMemReadAddr  <= iwReqAddr;
              orMemWriteAddr <= iwReqAddr;
              if (iwReqWrite) begin
                orMemWriteData <= w_wdata;
                orMemWstrb     <= w_wstrb;
              end
            end
          end
        end
        ST_ACCESS: begin
          orMemWstrb <= '0;
          orRspErr   <= 1'b0;
          orRspData  <= r_write ? '0 : w_ext;
        end
        default: begin
          orMemWstrb <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-addressed negedge memory model.
module tb_mem_access_unit;

  localparam int unsigned LP_BYTES = 176;

  logic        iwClk;
  logic        iwRst;
  logic        iwReqValid;
  logic        owReqReady;
  logic        iwReqWrite;
  logic [2:0]  iwReqFunct3;
  logic [31:0] iwReqAddr;
  logic [31:0] iwReqData;
  logic        owRspValid;
  logic        iwRspReady;
  logic [31:0] orRspData;
  logic        orRspErr;
  logic [31:0] orMemReadAddr;
  logic [31:0] orMemWriteAddr;
  logic [31:0] orMemWriteData;
  logic [3:0]  orMemWstrb;
  logic [31:0] iwMemReadData;

  int n_checks;
  int n_errors;

  logic [7:0] mem [0:LP_BYTES-1];

  mem_access_unit #(
    .pWords(32'd44),
    .pRspErrOnRange(1'b1)
  ) dut (
    .iwClk(iwClk),
    .iwRst(iwRst),
    .iwReqValid(iwReqValid),
    .owReqReady(owReqReady),
    .iwReqWrite(iwReqWrite),
    .iwReqFunct3(iwReqFunct3),
    .iwReqAddr(iwReqAddr),
    .iwReqData(iwReqData),
    .owRspValid(owRspValid),
    .iwRspReady(iwRspReady),
    .orRspData(orRspData),
    .orRspErr(orRspErr),
    .orMemReadAddr(orMemReadAddr),
    .orMemWriteAddr(orMemWriteAddr),
    .orMemWriteData(orMemWriteData),
    .orMemWstrb(orMemWstrb),
    .iwMemReadData(iwMemReadData)
  );

  initial iwClk = 1'b0;
  always #5 iwClk = ~iwClk;

  // Byte-addressed memory: writes and read-data refresh on the falling edge
  always @(negedge iwClk) begin
    logic [31:0] rd;
    rd = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((orMemReadAddr + i) < LP_BYTES) rd[8*i +: 8] = mem[orMemReadAddr + i];
      if (orMemWstrb[i] && ((orMemWriteAddr + i) < LP_BYTES))
        mem[orMemWriteAddr + i] <= orMemWriteData[8*i +: 8];
    end
    iwMemReadData <= rd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request at the next posedge and follows it to completion.
  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic exp_err, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rsp,
                        input int unsigned hold);
    chk({tag, ".ready_before"}, {31'h0, owReqReady}, 32'h1);
    iwReqValid  = 1'b1;
    iwReqWrite  = wr;
    iwReqFunct3 = f3;
    iwReqAddr   = addr;
    iwReqData   = data;
    @(posedge iwClk);
    #1;
    iwReqValid = 1'b0;
    if (!exp_err) begin
      chk({tag, ".acc_valid"}, {31'h0, owRspValid}, 32'h0);
      chk({tag, ".acc_ready"}, {31'h0, owReqReady}, 32'h0);
      chk({tag, ".acc_strb"}, {28'h0, orMemWstrb}, {28'h0, exp_strb});
      chk({tag, ".acc_raddr"}, orMemReadAddr, addr);
      chk({tag, ".acc_waddr"}, orMemWriteAddr, addr);
      if (wr) chk({tag, ".acc_wdata"}, orMemWriteData, exp_wdata);
      @(posedge iwClk);
      #1;
    end
    chk({tag, ".rsp_valid"}, {31'h0, owRspValid}, 32'h1);
    chk({tag, ".rsp_err"}, {31'h0, orRspErr}, {31'h0, exp_err});
    chk({tag, ".rsp_data"}, orRspData, exp_rsp);
    chk({tag, ".rsp_strb"}, {28'h0, orMemWstrb}, 32'h0);
    for (int unsigned k = 0; k < hold; k++) begin
      @(posedge iwClk);
      #1;
      chk({tag, ".hold_valid"}, {31'h0, owRspValid}, 32'h1);
      chk({tag, ".hold_ready"}, {31'h0, owReqReady}, 32'h0);
      chk({tag, ".hold_data"}, orRspData, exp_rsp);
    end
    iwRspReady = 1'b1;
    @(posedge iwClk);
    #1;
    iwRspReady = 1'b0;
    chk({tag, ".done_ready"}, {31'h0, owReqReady}, 32'h1);
    chk({tag, ".done_valid"}, {31'h0, owRspValid}, 32'h0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    iwRst       = 1'b1;
    iwReqValid  = 1'b0;
    iwReqWrite  = 1'b0;
    iwReqFunct3 = 3'b000;
    iwReqAddr   = '0;
    iwReqData   = '0;
    iwRspReady  = 1'b0;
    for (int unsigned i = 0; i < LP_BYTES; i++) mem[i] = 8'h00;
    repeat (3) @(posedge iwClk);
    #1;
    chk("rst.ready", {31'h0, owReqReady}, 32'h1);
    chk("rst.valid", {31'h0, owRspValid}, 32'h0);
    chk("rst.data", orRspData, 32'h0);
    chk("rst.err", {31'h0, orRspErr}, 32'h0);
    chk("rst.raddr", orMemReadAddr, 32'h0);
    chk("rst.waddr", orMemWriteAddr, 32'h0);
    chk("rst.wdata", orMemWriteData, 32'h0);
    chk("rst.strb", {28'h0, orMemWstrb}, 32'h0);
    iwRst = 1'b0;
    @(posedge iwClk);
    #1;

    // Reset during the ACCESS cycle of a store
    iwReqValid  = 1'b1;
    iwReqWrite  = 1'b1;
    iwReqFunct3 = 3'b010;
    iwReqAddr   = 32'h10;
    iwReqData   = 32'hA5A5A5A5;
    @(posedge iwClk);
    #1;
    iwReqValid = 1'b0;
    chk("midrst.strb_set", {28'h0, orMemWstrb}, 32'hF);
    iwRst = 1'b1;
    #1;
    chk("midrst.strb_async", {28'h0, orMemWstrb}, 32'h0);
    chk("midrst.valid", {31'h0, owRspValid}, 32'h0);
    @(posedge iwClk);
    #1;
    iwRst = 1'b0;
    @(posedge iwClk);
    #1;
    chk("midrst.ready_after", {31'h0, owReqReady}, 32'h1);
    chk("midrst.valid_after", {31'h0, owRspValid}, 32'h0);
    do_req("midrst.lw", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 0);

    // Word store and load back, then byte/half views of the same word
    do_req("sw08", 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0, 0);
    do_req("lw08", 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 0);
    do_req("lb0b", 1'b0, 3'b000, 32'h0B, 32'h0, 1'b0, 4'h0, 32'h0, 32'hFFFFFFDE, 0);
    do_req("lh0a", 1'b0, 3'b001, 32'h0A, 32'h0, 1'b0, 4'h0, 32'h0, 32'hFFFFDEAD, 0);

    // Byte store with masking; signed and unsigned byte loads
    do_req("sb20", 1'b1, 3'b000, 32'h20, 32'h12345680, 1'b0, 4'h1, 32'h00000080, 32'h0, 0);
    do_req("lb20", 1'b0, 3'b000, 32'h20, 32'h0, 1'b0, 4'h0, 32'h0, 32'hFFFFFF80, 0);
    do_req("lbu20", 1'b0, 3'b100, 32'h20, 32'h0, 1'b0, 4'h0, 32'h0, 32'h00000080, 0);

    // Halfword store; signed load held under backpressure, then unsigned load
    do_req("sh30", 1'b1, 3'b001, 32'h30, 32'hABCD8001, 1'b0, 4'h3, 32'h00008001, 32'h0, 0);
    do_req("lh30", 1'b0, 3'b001, 32'h30, 32'h0, 1'b0, 4'h0, 32'h0, 32'hFFFF8001, 5);
    do_req("lhu30", 1'b0, 3'b101, 32'h30, 32'h0, 1'b0, 4'h0, 32'h0, 32'h00008001, 0);

    // Range boundary and illegal funct3
    do_req("swac", 1'b1, 3'b010, 32'hAC, 32'hCAFEF00D, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0, 0);
    do_req("lwac", 1'b0, 3'b010, 32'hAC, 32'h0, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D, 0);
    do_req("lwad", 1'b0, 3'b010, 32'hAD, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 0);
    do_req("lbuaf", 1'b0, 3'b100, 32'hAF, 32'h0, 1'b0, 4'h0, 32'h0, 32'h000000CA, 0);
    do_req("shaf", 1'b1, 3'b001, 32'hAF, 32'h1234, 1'b1, 4'h0, 32'h0, 32'h0, 0);
    do_req("lwffff", 1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 0);
    do_req("st011", 1'b1, 3'b011, 32'h40, 32'h11111111, 1'b1, 4'h0, 32'h0, 32'h0, 0);
    do_req("st100", 1'b1, 3'b100, 32'h40, 32'h11111111, 1'b1, 4'h0, 32'h0, 32'h0, 0);
    do_req("ld110", 1'b0, 3'b110, 32'h40, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 0);
    do_req("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 0);

    // Misaligned word load
    do_req("sw00", 1'b1, 3'b010, 32'h00, 32'h44332211, 1'b0, 4'hF, 32'h44332211, 32'h0, 0);
    do_req("sw04", 1'b1, 3'b010, 32'h04, 32'h88776655, 1'b0, 4'hF, 32'h88776655, 32'h0, 0);
`ifdef MEMIF_ALIGN_CHECK_EN
    do_req("lw02", 1'b0, 3'b010, 32'h02, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 0);
`else
    do_req("lw02", 1'b0, 3'b010, 32'h02, 32'h0, 1'b0, 4'h0, 32'h0, 32'h66554433, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
